// File: rtl/mem_pkg.sv
// Shared definitions for the handshake memory.
//   state_t    : handshake FSM encoding (IDLE / WAIT / DONE)
//   OP_*       : opcode nibbles used to assemble the boot image
//   boot_word  : returns word idx of the 16-bit boot image (0 beyond the image)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BOOT_IMAGE_WORDS = 8;

  // Opcode field occupies bits 15:12 of each boot word.
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_ADD = 4'h6;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_BR  = 4'hE;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;

  function automatic logic [15:0] boot_word(input int idx);
    case (idx)
      0:       boot_word = {OP_LD,  12'h00C};
      1:       boot_word = {OP_ST,  12'h000};
      2:       boot_word = {OP_ADD, 12'h080};
      3:       boot_word = {OP_SUB, 12'h01F};
      4:       boot_word = {OP_BR,  12'h002};
      5:       boot_word = {OP_ST,  12'h080};
      6:       boot_word = {OP_AND, 12'h002};
      7:       boot_word = {OP_OR,  12'h081};
      default: boot_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Loadable 4-bit down-counter used to time memory wait states.
//   Clk      : clock
//   Reset    : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at zero
//   count    : current count
//   zero     : count == 0
module mem_wait_ctr (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  // NOTE: registers are updated with <= so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/handshake_mem.sv
// Clocked main memory serving a four-phase EN/MFC handshake with
// configurable wait states, a reset-reloaded boot region and a fault flag.
//   Clk      : clock, all state on rising edge
//   Reset    : synchronous active-high; aborts any transaction, reloads boot region
//   EN       : request strobe, held high until MFC is seen
//   RW       : 1 = read, 0 = write (captured with the request)
//   addr     : word address (captured with the request)
//   Data_in  : write data (captured with the request)
//   Data_out : registered read data, held until the next successful read
//   MFC      : memory function complete
//   Fault    : access rejected (out of range or protected boot write); valid with MFC
module handshake_mem
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int BOOT_WORDS  = 8,
  parameter int BOOT_PROT   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              EN,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              MFC,
  output logic              Fault
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BOOT_N = (BOOT_WORDS < DEPTH) ? BOOT_WORDS : DEPTH;

  // Compare limits carry one extra bit so DEPTH == 2**ADDR_W still fits.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] BOOT_LIM  = (ADDR_W+1)'(BOOT_WORDS);

  state_t              state;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  logic [3:0]          cnt;
  logic                cnt_zero;
  logic                cnt_load;
  logic                cnt_dec;

  logic                in_range;
  logic                boot_hit;
  logic                fault_cond;
  logic                access;
  logic                do_write;
  logic [IDX_W-1:0]    idx;

  assign in_range   = ({1'b0, addr_q} < DEPTH_LIM);
  assign boot_hit   = ({1'b0, addr_q} < BOOT_LIM);
  assign fault_cond = !in_range || (!rw_q && (BOOT_PROT != 0) && boot_hit);
  assign idx        = addr_q[IDX_W-1:0];

  // The array is touched exactly once per transaction: on the first DONE edge,
  // which is also the edge that raises MFC. This single point keeps the
  // WAIT_STATES=0 path identical to the others, and anything that aborts the
  // transaction earlier (Reset) leaves the array untouched.
  assign access   = (state == DONE) && !MFC;
  assign do_write = access && !rw_q && !fault_cond;

  assign cnt_load = (state == IDLE) && EN;
  assign cnt_dec  = (state == WAIT);

  mem_wait_ctr u_wait_ctr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (4'(WAIT_STATES)),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Handshake FSM with registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      MFC      <= 1'b0;
      Fault    <= 1'b0;
      Data_out <= '0;
      rw_q     <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (EN) begin
            rw_q   <= RW;
            addr_q <= addr;
            data_q <= Data_in;
            state  <= (WAIT_STATES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          // cnt_zero cannot occur here in normal operation; it only guards
          // against getting stuck if the counter is ever disturbed.
          if ((cnt == 4'd1) || cnt_zero) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!MFC) begin
            MFC   <= 1'b1;
            Fault <= fault_cond;
            if (rw_q && !fault_cond) begin
              Data_out <= mem[idx];
            end
          end else if (!EN) begin
            MFC   <= 1'b0;
            Fault <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: only the boot region is reset; the rest of the array keeps its
  // contents across Reset, so it stays a plain RAM rather than a register file.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < BOOT_N; i++) begin
        mem[i] <= DATA_W'(boot_word(i));
      end
    end else if (do_write) begin
      mem[idx] <= data_q;
    end
  end

endmodule
